uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 16x oversampling, optional parity, 1 or 2 stop bits,
// single-entry holding register with ack handshake and sticky overrun flag.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 UART_RX,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W    = 4;
    localparam int unsigned BIT_W   = 4;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_MID    = OS_W'(7);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_EN    = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;

    logic [DIV_W-1:0]       r_div_cnt;
    logic [OS_W-1:0]        r_os_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_ferr_acc;
    logic                   r_perr_acc;

    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_overrun;
    logic                   r_busy;

    logic                   w_tick;
    logic                   w_sample;
    logic                   w_fall;
    logic                   w_shift_en;
    logic                   w_par_en;
    logic                   w_stop_en;
    logic                   w_done;
    logic                   w_par_calc;
    logic                   w_perr_bit;
    logic                   w_ferr_new;
    logic                   w_load;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= UART_RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall   = r_rx_prev & ~r_rx_sync;
    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_sample = w_tick && (r_os_cnt == OS_MID);

    // Parity over payload plus received parity bit; the mismatch sense depends on mode
    assign w_par_calc = ^{r_shift, r_rx_sync};
    assign w_perr_bit = PAR_ODD ? ~w_par_calc : w_par_calc;
    assign w_ferr_new = r_ferr_acc | ~r_rx_sync;
    assign w_load     = w_done && (!r_rx_valid || rx_ack);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_stop_en   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_sample) begin
                    w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == DATA_LAST) begin
                        w_state_nxt = PAR_EN ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (w_sample) begin
                    w_par_en    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    w_stop_en = 1'b1;
                    if (r_bit_cnt == STOP_LAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Baud tick divider and oversample counter, held at zero while idle
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
        end else if (r_state == S_IDLE) begin
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick) begin
                r_os_cnt <= r_os_cnt + OS_W'(1);
            end
        end
    end

    // Frame assembly: bit counter restarts on every phase change
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ferr_acc <= 1'b0;
            r_perr_acc <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            end
            if (r_state == S_IDLE) begin
                r_ferr_acc <= 1'b0;
                r_perr_acc <= 1'b0;
            end else begin
                if (w_stop_en && !r_rx_sync) begin
                    r_ferr_acc <= 1'b1;
                end
                if (w_par_en) begin
                    r_perr_acc <= w_perr_bit;
                end
            end
        end
    end

    // Holding register and consumer handshake
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_load) begin
                r_rx_data    <= r_shift;
                r_rx_valid   <= 1'b1;
                r_frame_err  <= w_ferr_new;
                r_parity_err <= r_perr_acc;
                if (rx_ack && r_rx_valid) begin
                    r_overrun <= 1'b0;
                end
            end else if (w_done) begin
                r_overrun <= 1'b1;
            end else if (rx_ack && r_rx_valid) begin
                r_rx_valid   <= 1'b0;
                r_frame_err  <= 1'b0;
                r_parity_err <= 1'b0;
                r_overrun    <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule
